// File: rtl/glb_bank_arb_ctrl.sv
// glb_bank_arb_ctrl: single-port SRAM bank arbiter shared by config and packet ports.
// Config traffic takes the bank first; packet ports share the remaining slots round-robin.
module glb_bank_arb_ctrl #(
    parameter int NUM_PORTS      = 2,
    parameter int ADDR_WIDTH     = 17,
    parameter int DATA_WIDTH     = 64,
    parameter int CFG_DATA_WIDTH = 32,
    parameter int RD_LATENCY     = 3
) (
    input  logic                            clk,
    input  logic                            reset,
    input  logic [NUM_PORTS-1:0]            port_wr_en,
    input  logic [NUM_PORTS*ADDR_WIDTH-1:0] port_wr_addr,
    input  logic [NUM_PORTS*DATA_WIDTH-1:0] port_wr_data,
    input  logic [NUM_PORTS*DATA_WIDTH-1:0] port_wr_bit_sel,
    input  logic [NUM_PORTS-1:0]            port_rd_en,
    input  logic [NUM_PORTS*ADDR_WIDTH-1:0] port_rd_addr,
    output logic [NUM_PORTS-1:0]            port_gnt,
    output logic [NUM_PORTS*DATA_WIDTH-1:0] port_rd_data,
    output logic [NUM_PORTS-1:0]            port_rd_data_valid,
    input  logic                            cfg_wr_en,
    input  logic                            cfg_rd_en,
    input  logic [ADDR_WIDTH-1:0]           cfg_wr_addr,
    input  logic [ADDR_WIDTH-1:0]           cfg_rd_addr,
    input  logic [CFG_DATA_WIDTH-1:0]       cfg_wr_data,
    output logic [CFG_DATA_WIDTH-1:0]       cfg_rd_data,
    output logic                            cfg_rd_data_valid,
    output logic                            mem_wr_en,
    output logic                            mem_rd_en,
    output logic [ADDR_WIDTH-1:0]           mem_addr,
    output logic [DATA_WIDTH-1:0]           mem_data_in,
    output logic [DATA_WIDTH-1:0]           mem_data_in_bit_sel,
    input  logic [DATA_WIDTH-1:0]           mem_data_out
);

    localparam int RATIO   = DATA_WIDTH / CFG_DATA_WIDTH;
    localparam int LANE_W  = (RATIO > 1) ? $clog2(RATIO) : 1;
    localparam int LANE_LO = $clog2(CFG_DATA_WIDTH / 8);
    localparam int PID_W   = (NUM_PORTS > 1) ? $clog2(NUM_PORTS) : 1;
    localparam logic [DATA_WIDTH-1:0] CFG_MASK = DATA_WIDTH'({CFG_DATA_WIDTH{1'b1}});

    // Config word lane inside a bank word; a single lane when the widths match.
    function automatic logic [LANE_W-1:0] lane_of(input logic [ADDR_WIDTH-1:0] addr);
        lane_of = (RATIO > 1) ? LANE_W'(addr >> LANE_LO) : {LANE_W{1'b0}};
    endfunction

    logic [PID_W-1:0]     rr_ptr_q, rr_ptr_d;
    logic [NUM_PORTS-1:0] port_req_s;
    logic                 pkt_found_s;
    logic [PID_W-1:0]     pkt_win_s;
    logic [PID_W-1:0]     rr_next_s;
    logic                 issue_rd_s;
    logic                 issue_cfg_s;
    logic [PID_W-1:0]     issue_pid_s;
    logic [LANE_W-1:0]    issue_lane_s;

    logic                 tag_vld_q  [RD_LATENCY];
    logic                 tag_vld_d  [RD_LATENCY];
    logic                 tag_cfg_q  [RD_LATENCY];
    logic                 tag_cfg_d  [RD_LATENCY];
    logic [PID_W-1:0]     tag_pid_q  [RD_LATENCY];
    logic [PID_W-1:0]     tag_pid_d  [RD_LATENCY];
    logic [LANE_W-1:0]    tag_lane_q [RD_LATENCY];
    logic [LANE_W-1:0]    tag_lane_d [RD_LATENCY];

    logic [NUM_PORTS*DATA_WIDTH-1:0] port_rd_data_q, port_rd_data_d;
    logic [NUM_PORTS-1:0]            port_rd_data_valid_q, port_rd_data_valid_d;
    logic [CFG_DATA_WIDTH-1:0]       cfg_rd_data_q, cfg_rd_data_d;
    logic                            cfg_rd_data_valid_q, cfg_rd_data_valid_d;

    assign port_req_s = port_wr_en | port_rd_en;

    // Round-robin search: first requesting port at or after rr_ptr_q.
    always_comb begin
        int  cand;
        logic hit;
        pkt_found_s = 1'b0;
        pkt_win_s   = {PID_W{1'b0}};
        for (int k = 0; k < NUM_PORTS; k++) begin
            cand        = (int'(rr_ptr_q) + k) % NUM_PORTS;
            hit         = port_req_s[cand] && !pkt_found_s;
            pkt_win_s   = hit ? PID_W'(cand) : pkt_win_s;
            pkt_found_s = pkt_found_s | hit;
        end
        rr_next_s = (int'(pkt_win_s) == NUM_PORTS - 1) ? {PID_W{1'b0}} : PID_W'(int'(pkt_win_s) + 1);
    end

    // Issue stage: one SRAM access per cycle, cfg write > cfg read > packet.
    always_comb begin
        int win_i;
        win_i               = int'(pkt_win_s);
        mem_wr_en           = 1'b0;
        mem_rd_en           = 1'b0;
        mem_addr            = {ADDR_WIDTH{1'b0}};
        mem_data_in         = {DATA_WIDTH{1'b0}};
        mem_data_in_bit_sel = {DATA_WIDTH{1'b0}};
        port_gnt            = {NUM_PORTS{1'b0}};
        rr_ptr_d            = rr_ptr_q;
        issue_rd_s          = 1'b0;
        issue_cfg_s         = 1'b0;
        issue_pid_s         = {PID_W{1'b0}};
        issue_lane_s        = {LANE_W{1'b0}};
        if (cfg_wr_en) begin
            mem_wr_en           = 1'b1;
            mem_addr            = cfg_wr_addr;
            mem_data_in         = DATA_WIDTH'(cfg_wr_data) << (int'(lane_of(cfg_wr_addr)) * CFG_DATA_WIDTH);
            mem_data_in_bit_sel = CFG_MASK << (int'(lane_of(cfg_wr_addr)) * CFG_DATA_WIDTH);
        end else if (cfg_rd_en) begin
            mem_rd_en    = 1'b1;
            mem_addr     = cfg_rd_addr;
            issue_rd_s   = 1'b1;
            issue_cfg_s  = 1'b1;
            issue_lane_s = lane_of(cfg_rd_addr);
        end else if (pkt_found_s) begin
            port_gnt[pkt_win_s] = 1'b1;
            rr_ptr_d            = rr_next_s;
            // A port raising both strobes gets its write first; the read waits for a later grant.
            if (port_wr_en[pkt_win_s]) begin
                mem_wr_en           = 1'b1;
                mem_addr            = port_wr_addr[win_i*ADDR_WIDTH +: ADDR_WIDTH];
                mem_data_in         = port_wr_data[win_i*DATA_WIDTH +: DATA_WIDTH];
                mem_data_in_bit_sel = port_wr_bit_sel[win_i*DATA_WIDTH +: DATA_WIDTH];
            end else begin
                mem_rd_en   = 1'b1;
                mem_addr    = port_rd_addr[win_i*ADDR_WIDTH +: ADDR_WIDTH];
                issue_rd_s  = 1'b1;
                issue_pid_s = pkt_win_s;
            end
        end else begin
            rr_ptr_d = rr_ptr_q;
        end
    end

    // Read tag pipeline, one stage per cycle of SRAM latency.
    always_comb begin
        tag_vld_d[0]  = issue_rd_s;
        tag_cfg_d[0]  = issue_cfg_s;
        tag_pid_d[0]  = issue_pid_s;
        tag_lane_d[0] = issue_lane_s;
        for (int i = 1; i < RD_LATENCY; i++) begin
            tag_vld_d[i]  = tag_vld_q[i-1];
            tag_cfg_d[i]  = tag_cfg_q[i-1];
            tag_pid_d[i]  = tag_pid_q[i-1];
            tag_lane_d[i] = tag_lane_q[i-1];
        end
    end

    // Return steering: route SRAM data to its requester; data registers hold between returns.
    always_comb begin
        int pid_i;
        int base_i;
        pid_i                = int'(tag_pid_q[RD_LATENCY-1]);
        base_i               = int'(tag_lane_q[RD_LATENCY-1]) * CFG_DATA_WIDTH;
        port_rd_data_d       = port_rd_data_q;
        port_rd_data_valid_d = {NUM_PORTS{1'b0}};
        cfg_rd_data_d        = cfg_rd_data_q;
        cfg_rd_data_valid_d  = 1'b0;
        if (tag_vld_q[RD_LATENCY-1] && tag_cfg_q[RD_LATENCY-1]) begin
            cfg_rd_data_valid_d = 1'b1;
            cfg_rd_data_d       = mem_data_out[base_i +: CFG_DATA_WIDTH];
        end else if (tag_vld_q[RD_LATENCY-1]) begin
            port_rd_data_valid_d[pid_i]                  = 1'b1;
            port_rd_data_d[pid_i*DATA_WIDTH +: DATA_WIDTH] = mem_data_out;
        end else begin
            cfg_rd_data_valid_d = 1'b0;
        end
    end

    // State registers; reset drops every in-flight read tag.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            rr_ptr_q <= {PID_W{1'b0}};
            for (int i = 0; i < RD_LATENCY; i++) begin
                tag_vld_q[i]  <= 1'b0;
                tag_cfg_q[i]  <= 1'b0;
                tag_pid_q[i]  <= {PID_W{1'b0}};
                tag_lane_q[i] <= {LANE_W{1'b0}};
            end
            port_rd_data_q       <= {(NUM_PORTS*DATA_WIDTH){1'b0}};
            port_rd_data_valid_q <= {NUM_PORTS{1'b0}};
            cfg_rd_data_q        <= {CFG_DATA_WIDTH{1'b0}};
            cfg_rd_data_valid_q  <= 1'b0;
        end else begin
            rr_ptr_q <= rr_ptr_d;
            for (int i = 0; i < RD_LATENCY; i++) begin
                tag_vld_q[i]  <= tag_vld_d[i];
                tag_cfg_q[i]  <= tag_cfg_d[i];
                tag_pid_q[i]  <= tag_pid_d[i];
                tag_lane_q[i] <= tag_lane_d[i];
            end
            port_rd_data_q       <= port_rd_data_d;
            port_rd_data_valid_q <= port_rd_data_valid_d;
            cfg_rd_data_q        <= cfg_rd_data_d;
            cfg_rd_data_valid_q  <= cfg_rd_data_valid_d;
        end
    end

    assign port_rd_data       = port_rd_data_q;
    assign port_rd_data_valid = port_rd_data_valid_q;
    assign cfg_rd_data        = cfg_rd_data_q;
    assign cfg_rd_data_valid  = cfg_rd_data_valid_q;

endmodule

// File: tb/tb_glb_bank_arb_ctrl.sv
// Directed bench for glb_bank_arb_ctrl (2-port default build) plus a 4-port/128-bit/latency-5
// build driven with random per-port traffic and scored against a reference memory.
module tb_glb_bank_arb_ctrl;
    localparam int AW = 17;

    logic clk = 1'b0;
    logic reset;
    logic preload;
    always #5 clk = ~clk;

    // Default build: 2 ports, 64-bit words, 32-bit cfg, latency 3
    logic [1:0]      a_wr_en, a_rd_en, a_gnt, a_rd_vld;
    logic [2*AW-1:0] a_wr_addr, a_rd_addr;
    logic [127:0]    a_wr_data, a_bit_sel, a_rd_data;
    logic            a_cfg_wr_en, a_cfg_rd_en, a_cfg_rd_vld;
    logic [AW-1:0]   a_cfg_wr_addr, a_cfg_rd_addr, a_mem_addr;
    logic [31:0]     a_cfg_wr_data, a_cfg_rd_data;
    logic            a_mem_wr_en, a_mem_rd_en;
    logic [63:0]     a_mem_din, a_mem_bs, a_mem_dout;

    // Wide build: 4 ports, 128-bit words, latency 5
    logic [3:0]      b_wr_en, b_rd_en, b_gnt, b_rd_vld;
    logic [4*AW-1:0] b_wr_addr, b_rd_addr;
    logic [511:0]    b_wr_data, b_bit_sel, b_rd_data;
    logic            b_cfg_wr_en, b_cfg_rd_en, b_cfg_rd_vld;
    logic [AW-1:0]   b_cfg_wr_addr, b_cfg_rd_addr, b_mem_addr;
    logic [31:0]     b_cfg_wr_data, b_cfg_rd_data;
    logic            b_mem_wr_en, b_mem_rd_en;
    logic [127:0]    b_mem_din, b_mem_bs, b_mem_dout;

    glb_bank_arb_ctrl u_dut_a (
        .clk(clk), .reset(reset),
        .port_wr_en(a_wr_en), .port_wr_addr(a_wr_addr), .port_wr_data(a_wr_data),
        .port_wr_bit_sel(a_bit_sel), .port_rd_en(a_rd_en), .port_rd_addr(a_rd_addr),
        .port_gnt(a_gnt), .port_rd_data(a_rd_data), .port_rd_data_valid(a_rd_vld),
        .cfg_wr_en(a_cfg_wr_en), .cfg_rd_en(a_cfg_rd_en),
        .cfg_wr_addr(a_cfg_wr_addr), .cfg_rd_addr(a_cfg_rd_addr),
        .cfg_wr_data(a_cfg_wr_data), .cfg_rd_data(a_cfg_rd_data), .cfg_rd_data_valid(a_cfg_rd_vld),
        .mem_wr_en(a_mem_wr_en), .mem_rd_en(a_mem_rd_en), .mem_addr(a_mem_addr),
        .mem_data_in(a_mem_din), .mem_data_in_bit_sel(a_mem_bs), .mem_data_out(a_mem_dout)
    );

    glb_bank_arb_ctrl #(.NUM_PORTS(4), .ADDR_WIDTH(AW), .DATA_WIDTH(128),
                        .CFG_DATA_WIDTH(32), .RD_LATENCY(5)) u_dut_b (
        .clk(clk), .reset(reset),
        .port_wr_en(b_wr_en), .port_wr_addr(b_wr_addr), .port_wr_data(b_wr_data),
        .port_wr_bit_sel(b_bit_sel), .port_rd_en(b_rd_en), .port_rd_addr(b_rd_addr),
        .port_gnt(b_gnt), .port_rd_data(b_rd_data), .port_rd_data_valid(b_rd_vld),
        .cfg_wr_en(b_cfg_wr_en), .cfg_rd_en(b_cfg_rd_en),
        .cfg_wr_addr(b_cfg_wr_addr), .cfg_rd_addr(b_cfg_rd_addr),
        .cfg_wr_data(b_cfg_wr_data), .cfg_rd_data(b_cfg_rd_data), .cfg_rd_data_valid(b_cfg_rd_vld),
        .mem_wr_en(b_mem_wr_en), .mem_rd_en(b_mem_rd_en), .mem_addr(b_mem_addr),
        .mem_data_in(b_mem_din), .mem_data_in_bit_sel(b_mem_bs), .mem_data_out(b_mem_dout)
    );

    // SRAM models: write/read sampled at the edge, read data visible RD_LATENCY cycles after issue
    logic [63:0]  sram_a [16];
    logic [63:0]  pipe_a [3];
    logic [127:0] sram_b [16];
    logic [127:0] pipe_b [5];

    always @(posedge clk) begin
        if (preload) begin
            for (int w = 0; w < 16; w++) sram_a[w] <= {32'hA000_0000 + 32'(w), 32'hB000_0000 + 32'(w)};
        end else if (a_mem_wr_en) begin
            sram_a[a_mem_addr[6:3]] <= (sram_a[a_mem_addr[6:3]] & ~a_mem_bs) | (a_mem_din & a_mem_bs);
        end
        pipe_a[0] <= a_mem_rd_en ? sram_a[a_mem_addr[6:3]] : 64'h0;
        for (int i = 1; i < 3; i++) pipe_a[i] <= pipe_a[i-1];
    end
    assign a_mem_dout = pipe_a[2];

    always @(posedge clk) begin
        if (preload) begin
            for (int w = 0; w < 16; w++) sram_b[w] <= {4{32'hC000_0000 + 32'(w)}};
        end else if (b_mem_wr_en) begin
            sram_b[b_mem_addr[7:4]] <= (sram_b[b_mem_addr[7:4]] & ~b_mem_bs) | (b_mem_din & b_mem_bs);
        end
        pipe_b[0] <= b_mem_rd_en ? sram_b[b_mem_addr[7:4]] : 128'h0;
        for (int i = 1; i < 5; i++) pipe_b[i] <= pipe_b[i-1];
    end
    assign b_mem_dout = pipe_b[4];

    int n_chk;
    int n_pass;

    task automatic chk(input string tag, input logic [127:0] got, input logic [127:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h", tag, got, exp);
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    localparam logic [63:0] W0 = 64'hA000_0000_B000_0000;
    localparam logic [63:0] W1 = 64'hA000_0001_B000_0001;

    logic [127:0] ref_b [16];
    logic [127:0] expq [4][$];
    logic [3:0]   acc_wr, acc_rd, req_v, exp_g;
    int           rr_m;

    initial begin
        n_chk = 0; n_pass = 0;
        reset = 1'b1; preload = 1'b1;
        a_wr_en = '0; a_rd_en = '0; a_wr_addr = '0; a_rd_addr = '0; a_wr_data = '0; a_bit_sel = '0;
        a_cfg_wr_en = 1'b0; a_cfg_rd_en = 1'b0; a_cfg_wr_addr = '0; a_cfg_rd_addr = '0; a_cfg_wr_data = '0;
        b_wr_en = '0; b_rd_en = '0; b_wr_addr = '0; b_rd_addr = '0; b_wr_data = '0; b_bit_sel = '0;
        b_cfg_wr_en = 1'b0; b_cfg_rd_en = 1'b0; b_cfg_wr_addr = '0; b_cfg_rd_addr = '0; b_cfg_wr_data = '0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("rst_gnt", 128'(a_gnt), 128'd0);
        chk("rst_vld", 128'({a_rd_vld, a_cfg_rd_vld}), 128'd0);
        chk("rst_rdata", a_rd_data, 128'd0);
        chk("rst_cfgdata", 128'(a_cfg_rd_data), 128'd0);
        chk("rst_mem", 128'({a_mem_wr_en, a_mem_rd_en, a_mem_addr, a_mem_din, a_mem_bs}), 128'd0);
        reset = 1'b0; preload = 1'b0;

        // Both ports stream reads: grants alternate, returns follow in issue order
        a_rd_addr = {17'h8, 17'h0};
        for (int c = 0; c < 9; c++) begin
            step();
            a_rd_en = (c < 4) ? 2'b11 : 2'b00;
            @(negedge clk);
            if (c < 4) begin
                chk("rr_gnt", 128'(a_gnt), (c % 2 == 0) ? 128'd1 : 128'd2);
                chk("rr_addr", 128'(a_mem_addr), (c % 2 == 0) ? 128'h0 : 128'h8);
            end else if (c < 8) begin
                chk("rr_vld", 128'(a_rd_vld), (c % 2 == 0) ? 128'd1 : 128'd2);
                chk("rr_data", (c % 2 == 0) ? 128'(a_rd_data[63:0]) : 128'(a_rd_data[127:64]),
                    (c % 2 == 0) ? 128'(W0) : 128'(W1));
            end else begin
                chk("rr_idle", 128'(a_rd_vld), 128'd0);
            end
        end

        // cfg write to lane 1 steals the slot from port 0, which is granted next cycle
        step();
        a_cfg_wr_en = 1'b1; a_cfg_wr_addr = 17'h4; a_cfg_wr_data = 32'hDEAD_BEEF;
        a_wr_en = 2'b01; a_wr_addr[16:0] = 17'h10; a_wr_data[63:0] = 64'hCAFE_0000_0000_BEEF;
        a_bit_sel[63:0] = 64'hFFFF_FFFF_FFFF_FFFF;
        @(negedge clk);
        chk("cfgw_gnt", 128'(a_gnt), 128'd0);
        chk("cfgw_en", 128'({a_mem_wr_en, a_mem_rd_en}), 128'd2);
        chk("cfgw_addr", 128'(a_mem_addr), 128'h4);
        chk("cfgw_din", 128'(a_mem_din), 128'hDEAD_BEEF_0000_0000);
        chk("cfgw_bs", 128'(a_mem_bs), 128'hFFFF_FFFF_0000_0000);
        step();
        a_cfg_wr_en = 1'b0;
        @(negedge clk);
        chk("pw_gnt", 128'(a_gnt), 128'd1);
        chk("pw_din", 128'(a_mem_din), 128'hCAFE_0000_0000_BEEF);
        chk("pw_addr", 128'(a_mem_addr), 128'h10);

        // Port 0 writes word 0, then a cfg read of its upper lane
        step();
        a_wr_addr[16:0] = 17'h0; a_wr_data[63:0] = 64'h1111_2222_3333_4444;
        @(negedge clk);
        chk("pw2_gnt", 128'(a_gnt), 128'd1);
        for (int c = 0; c < 6; c++) begin
            step();
            a_wr_en = 2'b00;
            a_cfg_rd_en = (c == 0); a_cfg_rd_addr = 17'h4;
            @(negedge clk);
            if (c == 0) begin
                chk("cfgr_issue", 128'({a_mem_rd_en, a_gnt}), 128'h4);
            end else if (c == 4) begin
                chk("cfgr_vld", 128'(a_cfg_rd_vld), 128'd1);
                chk("cfgr_data", 128'(a_cfg_rd_data), 128'h1111_2222);
            end else if (c == 5) begin
                chk("cfgr_hold_vld", 128'(a_cfg_rd_vld), 128'd0);
                chk("cfgr_hold_data", 128'(a_cfg_rd_data), 128'h1111_2222);
            end else begin
                chk("cfgr_wait", 128'(a_cfg_rd_vld), 128'd0);
            end
        end

        // cfg write beats a simultaneous cfg read; the read then sees the lane-0 write
        for (int c = 0; c < 6; c++) begin
            step();
            a_cfg_wr_en = (c == 0); a_cfg_wr_addr = 17'h28; a_cfg_wr_data = 32'h1234_5678;
            a_cfg_rd_en = (c < 2); a_cfg_rd_addr = 17'h28;
            @(negedge clk);
            if (c == 0) begin
                chk("prio_en", 128'({a_mem_wr_en, a_mem_rd_en}), 128'd2);
                chk("prio_din", 128'(a_mem_din), 128'h0000_0000_1234_5678);
                chk("prio_bs", 128'(a_mem_bs), 128'h0000_0000_FFFF_FFFF);
            end else if (c == 1) begin
                chk("prio_rd", 128'({a_mem_wr_en, a_mem_rd_en}), 128'd1);
            end else if (c == 5) begin
                chk("lane0_vld", 128'(a_cfg_rd_vld), 128'd1);
                chk("lane0_data", 128'(a_cfg_rd_data), 128'h1234_5678);
            end else begin
                chk("lane0_wait", 128'(a_cfg_rd_vld), 128'd0);
            end
        end

        // Port 1 raises write and read together: write first, read next cycle, read sees write
        a_wr_addr[33:17] = 17'h20; a_rd_addr[33:17] = 17'h20;
        a_wr_data[127:64] = 64'h0123_4567_89AB_CDEF; a_bit_sel[127:64] = 64'hFFFF_FFFF_FFFF_FFFF;
        for (int c = 0; c < 6; c++) begin
            step();
            a_wr_en = (c == 0) ? 2'b10 : 2'b00;
            a_rd_en = (c < 2) ? 2'b10 : 2'b00;
            @(negedge clk);
            if (c == 0) begin
                chk("wr_rd_gnt0", 128'(a_gnt), 128'd2);
                chk("wr_rd_en0", 128'({a_mem_wr_en, a_mem_rd_en}), 128'd2);
            end else if (c == 1) begin
                chk("wr_rd_gnt1", 128'(a_gnt), 128'd2);
                chk("wr_rd_en1", 128'({a_mem_wr_en, a_mem_rd_en}), 128'd1);
            end else if (c == 5) begin
                chk("wr_rd_vld", 128'(a_rd_vld), 128'd2);
                chk("wr_rd_data", 128'(a_rd_data[127:64]), 128'h0123_4567_89AB_CDEF);
            end else begin
                chk("wr_rd_quiet", 128'({a_gnt, a_rd_vld}), 128'd0);
            end
        end

        // Reset one cycle after a read issue: that read never returns
        for (int c = 0; c < 9; c++) begin
            step();
            a_rd_en = (c == 0) ? 2'b01 : 2'b00;
            a_rd_addr[16:0] = 17'h0;
            if (c == 1) reset = 1'b1;
            if (c == 3) reset = 1'b0;
            @(negedge clk);
            if (c == 0) begin
                chk("rstf_gnt", 128'(a_gnt), 128'd1);
            end else if (c < 3) begin
                chk("rstf_vld", 128'({a_rd_vld, a_cfg_rd_vld, a_gnt}), 128'd0);
                chk("rstf_data", a_rd_data, 128'd0);
                chk("rstf_cfg", 128'(a_cfg_rd_data), 128'd0);
                chk("rstf_mem", 128'({a_mem_wr_en, a_mem_rd_en, a_mem_addr, a_mem_din, a_mem_bs}), 128'd0);
            end else begin
                chk("rstf_noret", 128'(a_rd_vld), 128'd0);
            end
        end
        for (int c = 0; c < 5; c++) begin
            step();
            a_rd_en = (c == 0) ? 2'b10 : 2'b00;
            a_rd_addr[33:17] = 17'h8;
            @(negedge clk);
            if (c == 0) chk("post_gnt", 128'(a_gnt), 128'd2);
            else if (c == 4) chk("post_data", 128'({a_rd_vld, a_rd_data[127:64]}), {62'd0, 2'b10, W1});
            else chk("post_wait", 128'(a_rd_vld), 128'd0);
        end

        // Wide build: random per-port traffic, each port owning four words of the bank
        for (int w = 0; w < 16; w++) ref_b[w] = {4{32'hC000_0000 + 32'(w)}};
        rr_m = 0; acc_wr = '0; acc_rd = '0;
        for (int c = 0; c < 320; c++) begin
            step();
            for (int p = 0; p < 4; p++) begin
                if (acc_wr[p]) b_wr_en[p] = 1'b0;
                if (acc_rd[p]) b_rd_en[p] = 1'b0;
                if (!b_wr_en[p] && !b_rd_en[p] && c < 280 && $urandom_range(0, 3) != 0) begin
                    int kind;
                    kind = int'($urandom_range(0, 2));
                    b_wr_addr[p*AW +: AW] = AW'((p * 4 + int'($urandom_range(0, 3))) * 16);
                    b_rd_addr[p*AW +: AW] = AW'((p * 4 + int'($urandom_range(0, 3))) * 16);
                    b_wr_data[p*128 +: 128] = {$urandom, $urandom, $urandom, $urandom};
                    b_bit_sel[p*128 +: 128] = ($urandom_range(0, 1) == 1) ? {128{1'b1}}
                                              : {$urandom, $urandom, $urandom, $urandom};
                    b_wr_en[p] = (kind != 1);
                    b_rd_en[p] = (kind != 0);
                end
            end
            acc_wr = '0; acc_rd = '0;
            @(negedge clk);
            for (int p = 0; p < 4; p++) begin
                if (b_rd_vld[p]) begin
                    chk("rnd_pending", 128'(expq[p].size() > 0), 128'd1);
                    if (expq[p].size() > 0) chk("rnd_data", b_rd_data[p*128 +: 128], expq[p].pop_front());
                end
            end
            req_v = b_wr_en | b_rd_en;
            exp_g = '0;
            for (int k = 0; k < 4; k++) begin
                int cand;
                cand = (rr_m + k) % 4;
                if (req_v[cand] && exp_g == 4'd0) exp_g[cand] = 1'b1;
            end
            chk("rnd_gnt", 128'(b_gnt), 128'(exp_g));
            for (int p = 0; p < 4; p++) begin
                if (exp_g[p]) begin
                    if (b_wr_en[p]) begin
                        ref_b[b_wr_addr[p*AW+4 +: 4]] = (ref_b[b_wr_addr[p*AW+4 +: 4]] & ~b_bit_sel[p*128 +: 128])
                                                      | (b_wr_data[p*128 +: 128] & b_bit_sel[p*128 +: 128]);
                        acc_wr[p] = 1'b1;
                    end else begin
                        expq[p].push_back(ref_b[b_rd_addr[p*AW+4 +: 4]]);
                        acc_rd[p] = 1'b1;
                    end
                    rr_m = (p + 1) % 4;
                end
            end
        end
        for (int p = 0; p < 4; p++) chk("rnd_drain", 128'(expq[p].size()), 128'd0);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
